debounce_multi: RTL and testbench

Parametrised multi-channel switch/button debouncer for HPS/FPGA board I/O (push-buttons, DIP switches). It is the successor to the fixed 4-bit debounce: channel count, polarity, timeout and synchronizer depth are generic. It adds per-channel press/release pulses, a global enable and a change flag. The block sits between raw pad inputs and the PIO/Avalon register slaves.

---
 rtl/debounce_multi.sv | 125 ++++++++++++
 tb/tb_debounce_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: parametrised multi-channel switch/button debouncer.
// Each channel is synchronised, then must hold a new level for TIMEOUT
// enabled cycles before data_out follows it; the accepted change is
// reported with a one-cycle press or release pulse and a shared any_change.
module debounce_multi #(
  parameter int    WIDTH         = 4,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_change
);

  localparam bit ACTIVE_LOW = (POLARITY == "LOW");
  localparam logic [WIDTH-1:0] INACT = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam longint MAX_TIMEOUT = (longint'(1) << TIMEOUT_WIDTH) - 1;
  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT - 1);

  // Parameter sanity: a bad TIMEOUT, a too-short synchroniser or an unknown
  // polarity would silently build a broken debouncer, so refuse to elaborate.
  if (TIMEOUT < 1 || longint'(TIMEOUT) > MAX_TIMEOUT) begin : g_badTimeout
    $error("debounce_multi: TIMEOUT must be in 1 .. 2**TIMEOUT_WIDTH-1");
  end
  if (SYNC_STAGES < 2) begin : g_badSync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end
  if (POLARITY != "LOW" && POLARITY != "HIGH") begin : g_badPolarity
    $error("debounce_multi: POLARITY must be \"LOW\" or \"HIGH\"");
  end

  typedef enum logic {STABLE, COUNTING} chanState_e;

  logic [WIDTH-1:0]         syncChain_q [SYNC_STAGES];
  logic [WIDTH-1:0]         syncOut;
  chanState_e               state_q     [WIDTH];
  logic [TIMEOUT_WIDTH-1:0] count_q     [WIDTH];
  logic [WIDTH-1:0]         dataOut_q;
  logic [WIDTH-1:0]         press_q;
  logic [WIDTH-1:0]         release_q;
  logic                     anyChange_q;

  logic [WIDTH-1:0]         differ;
  logic [WIDTH-1:0]         fire_d;
  logic [WIDTH-1:0]         activeNext;
  logic [WIDTH-1:0]         dataOut_d;
  logic [WIDTH-1:0]         press_d;
  logic [WIDTH-1:0]         release_d;

  // Synchroniser chain for the asynchronous pad inputs; it runs even while
  // the debouncer is disabled so the sampled level is always current.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= INACT;
      end
    end else begin
      syncChain_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= syncChain_q[s-1];
      end
    end
  end

  assign syncOut = syncChain_q[SYNC_STAGES-1];

  // Decide which channels accept their new level this cycle and classify
  // each accepted change as a press or a release for the configured polarity.
  always_comb begin
    differ = syncOut ^ dataOut_q;
    fire_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fire_d[i] = enable && differ[i] && (count_q[i] == LAST_COUNT);
    end
    activeNext = ACTIVE_LOW ? ~syncOut : syncOut;
    press_d    = fire_d & activeNext;
    release_d  = fire_d & ~activeNext;
    dataOut_d  = (dataOut_q & ~fire_d) | (syncOut & fire_d);
  end

  // Per-channel STABLE/COUNTING machines plus the registered outputs. A
  // mismatch that disappears before the terminal count, or a disabled cycle,
  // drops the channel back to STABLE with a cleared counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        count_q[i] <= '0;
      end
      dataOut_q   <= INACT;
      press_q     <= '0;
      release_q   <= '0;
      anyChange_q <= 1'b0;
    end else begin
      dataOut_q   <= dataOut_d;
      press_q     <= press_d;
      release_q   <= release_d;
      anyChange_q <= |fire_d;
      for (int i = 0; i < WIDTH; i++) begin
        if (!enable || !differ[i] || fire_d[i]) begin
          state_q[i] <= STABLE;
          count_q[i] <= '0;
        end else if (state_q[i] == STABLE) begin
          state_q[i] <= COUNTING;
          count_q[i] <= TIMEOUT_WIDTH'(1);
        end else begin
          count_q[i] <= count_q[i] + 1'b1;
        end
      end
    end
  end

  assign data_out      = dataOut_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_change    = anyChange_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed bench for debounce_multi. Two instances are
// exercised: active-low with TIMEOUT=8 and active-high with TIMEOUT=1.
// Every accepted level change is queued with the cycle it is due on; each
// cycle the monitors either pop and compare that event or require the
// outputs to hold their last expected level with no pulses.
module tb_debounce_multi;

  typedef struct {
    int         due;
    logic [3:0] dout;
    logic [3:0] press;
    logic [3:0] rel;
  } evT;

  logic       clk = 1'b0;
  logic       reset;
  logic       enableLow;
  logic       enableHigh;
  logic [3:0] dataInLow;
  logic [3:0] dataInHigh;
  logic [3:0] doutLow, pressLow, relLow;
  logic [3:0] doutHigh, pressHigh, relHigh;
  logic       anyLow, anyHigh;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         monOn = 1'b0;
  evT         qLow[$];
  evT         qHigh[$];
  logic [3:0] stableLow;
  logic [3:0] stableHigh;
  evT         evLow;
  evT         evHigh;

  debounce_multi #(
    .WIDTH(4), .POLARITY("LOW"), .TIMEOUT(8), .TIMEOUT_WIDTH(16), .SYNC_STAGES(2)
  ) dutLow (
    .clk(clk), .reset(reset), .enable(enableLow), .data_in(dataInLow),
    .data_out(doutLow), .press_pulse(pressLow), .release_pulse(relLow),
    .any_change(anyLow)
  );

  debounce_multi #(
    .WIDTH(4), .POLARITY("HIGH"), .TIMEOUT(1), .TIMEOUT_WIDTH(16), .SYNC_STAGES(2)
  ) dutHigh (
    .clk(clk), .reset(reset), .enable(enableHigh), .data_in(dataInHigh),
    .data_out(doutHigh), .press_pulse(pressHigh), .release_pulse(relHigh),
    .any_change(anyHigh)
  );

  // Free-running clock and a posedge counter used to time-stamp events.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit toHigh, input logic [3:0] value);
    if (toHigh) dataInHigh = value;
    else        dataInLow  = value;
  endtask

  task automatic expectEvent(input bit toHigh, input int delay, input logic [3:0] dout,
                             input logic [3:0] press, input logic [3:0] rel);
    evT e;
    e.due = cyc + delay;
    e.dout = dout;
    e.press = press;
    e.rel = rel;
    if (toHigh) qHigh.push_back(e);
    else        qLow.push_back(e);
  endtask

  // Scoreboard monitor for the active-low instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (monOn) begin
      if (qLow.size() > 0 && qLow[0].due == cyc) begin
        evLow = qLow.pop_front();
        stableLow = evLow.dout;
        checkOutput("lowDoutEvent", doutLow, evLow.dout);
        checkOutput("lowPressEvent", pressLow, evLow.press);
        checkOutput("lowReleaseEvent", relLow, evLow.rel);
        checkOutput("lowAnyEvent", {3'b000, anyLow}, {3'b000, |(evLow.press | evLow.rel)});
      end else begin
        checkOutput("lowDoutHold", doutLow, stableLow);
        checkOutput("lowPressIdle", pressLow, 4'b0000);
        checkOutput("lowReleaseIdle", relLow, 4'b0000);
        checkOutput("lowAnyIdle", {3'b000, anyLow}, 4'b0000);
      end
    end
  end

  // Scoreboard monitor for the active-high instance.
  always @(negedge clk) begin
    if (monOn) begin
      if (qHigh.size() > 0 && qHigh[0].due == cyc) begin
        evHigh = qHigh.pop_front();
        stableHigh = evHigh.dout;
        checkOutput("highDoutEvent", doutHigh, evHigh.dout);
        checkOutput("highPressEvent", pressHigh, evHigh.press);
        checkOutput("highReleaseEvent", relHigh, evHigh.rel);
        checkOutput("highAnyEvent", {3'b000, anyHigh}, {3'b000, |(evHigh.press | evHigh.rel)});
      end else begin
        checkOutput("highDoutHold", doutHigh, stableHigh);
        checkOutput("highPressIdle", pressHigh, 4'b0000);
        checkOutput("highReleaseIdle", relHigh, 4'b0000);
        checkOutput("highAnyIdle", {3'b000, anyHigh}, 4'b0000);
      end
    end
  end

  initial begin
    reset = 1'b1;
    enableLow = 1'b1;
    enableHigh = 1'b1;
    applyStimulus(0, 4'b0000);
    applyStimulus(1, 4'b0000);
    stableLow = 4'b1111;
    stableHigh = 4'b0000;

    // Reset held for three edges; outputs checked while still in reset.
    waitCycles(2);
    monOn = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    $display("[TB] reset released, all low channels pressed");
    expectEvent(0, 10, 4'b0000, 4'b1111, 4'b0000);
    waitCycles(12);

    // Return to idle, then a clean press and release on channel 2.
    applyStimulus(0, 4'b1111);
    expectEvent(0, 10, 4'b1111, 4'b0000, 4'b1111);
    waitCycles(12);
    applyStimulus(0, 4'b1011);
    expectEvent(0, 10, 4'b1011, 4'b0100, 4'b0000);
    waitCycles(12);
    applyStimulus(0, 4'b1111);
    expectEvent(0, 10, 4'b1111, 4'b0000, 4'b0100);
    waitCycles(12);

    // Bounce on channel 1: 3-cycle toggles never reach the timeout.
    $display("[TB] bounce on channel 1");
    for (int t = 0; t < 14; t++) begin
      applyStimulus(0, (t % 2 == 0) ? 4'b1101 : 4'b1111);
      waitCycles(3);
    end
    applyStimulus(0, 4'b1101);
    expectEvent(0, 10, 4'b1101, 4'b0010, 4'b0000);
    waitCycles(12);
    applyStimulus(0, 4'b1111);
    expectEvent(0, 10, 4'b1111, 4'b0000, 4'b0010);
    waitCycles(12);

    // Enable dropped at count 5 on channel 0, restored 20 cycles later.
    $display("[TB] enable gap on channel 0");
    applyStimulus(0, 4'b1110);
    waitCycles(7);
    enableLow = 1'b0;
    waitCycles(20);
    enableLow = 1'b1;
    expectEvent(0, 8, 4'b1110, 4'b0001, 4'b0000);
    waitCycles(10);
    applyStimulus(0, 4'b1111);
    expectEvent(0, 10, 4'b1111, 4'b0000, 4'b0001);
    waitCycles(12);

    // Reset mid-count on channel 0 while channel 3 is pressed.
    $display("[TB] reset during a count");
    applyStimulus(0, 4'b0111);
    expectEvent(0, 10, 4'b0111, 4'b1000, 4'b0000);
    waitCycles(12);
    applyStimulus(0, 4'b0110);
    waitCycles(8);
    reset = 1'b1;
    applyStimulus(0, 4'b1111);
    expectEvent(0, 1, 4'b1111, 4'b0000, 4'b0000);
    waitCycles(3);
    reset = 1'b0;
    waitCycles(15);
    applyStimulus(0, 4'b1110);
    expectEvent(0, 10, 4'b1110, 4'b0001, 4'b0000);
    waitCycles(12);
    applyStimulus(0, 4'b1111);
    expectEvent(0, 10, 4'b1111, 4'b0000, 4'b0001);
    waitCycles(12);

    // Active-high, TIMEOUT=1: press, one-cycle glitch, release.
    $display("[TB] active-high instance");
    applyStimulus(1, 4'b1000);
    expectEvent(1, 3, 4'b1000, 4'b1000, 4'b0000);
    waitCycles(6);
    applyStimulus(1, 4'b0000);
    expectEvent(1, 3, 4'b0000, 4'b0000, 4'b1000);
    expectEvent(1, 4, 4'b1000, 4'b1000, 4'b0000);
    waitCycles(1);
    applyStimulus(1, 4'b1000);
    waitCycles(6);
    applyStimulus(1, 4'b0000);
    expectEvent(1, 3, 4'b0000, 4'b0000, 4'b1000);
    waitCycles(6);

    // Every queued event must have been consumed.
    monOn = 1'b0;
    checkOutput("lowQueueDrained", 4'(qLow.size()), 4'd0);
    checkOutput("highQueueDrained", 4'(qHigh.size()), 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
